// File: rtl/tspi_master_if.sv
// Bus-side bundle between the register front-end (master) and the TSPI engine (slave).
interface tspi_master_if #(
    parameter int unsigned DivWidth = 8,
    parameter int unsigned LenWidth = 8
);
    logic [DivWidth-1:0] clk_div;
    logic [LenWidth-1:0] len;
    logic                start;
    logic                busy;
    logic                done;
    logic [7:0]          tx_data;
    logic                tx_valid;
    logic                tx_ready;
    logic [7:0]          rx_data;
    logic                rx_valid;

    modport master (
        output clk_div, len, start, tx_data, tx_valid,
        input  busy, done, tx_ready, rx_data, rx_valid
    );

    modport slave (
        input  clk_div, len, start, tx_data, tx_valid,
        output busy, done, tx_ready, rx_data, rx_valid
    );
endinterface

// File: rtl/tspi_master.sv
// Byte-oriented SPI mode-0 master: CS framing, MSB-first shifting on a divided SCK,
// per-byte TX handshake and RX pulse. All outputs come straight from flops.
module tspi_master #(
    parameter int unsigned DivWidth = 8,
    parameter int unsigned LenWidth = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    tspi_master_if.slave bus,
    output logic         tspi_clk_o,
    output logic         tspi_mosi_o,
    input  logic         tspi_miso_i,
    output logic         tspi_cs_no
);
    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        LOAD,
        SHIFT,
        CS_HOLD,
        CS_GAP
    } state_e;

    state_e              state_q;
    logic [DivWidth-1:0] div_q;
    logic [DivWidth-1:0] cnt_q;
    logic [LenWidth-1:0] left_q;
    logic [3:0]          tog_q;
    logic [6:0]          tx_sh_q;
    logic [7:0]          rx_sh_q;
    logic [7:0]          rx_data_q;
    logic                sck_q;
    logic                mosi_q;
    logic                cs_n_q;
    logic                ready_q;
    logic                rx_valid_q;
    logic                done_q;
    logic                busy_q;
    logic                div_tick;

    assign div_tick = (cnt_q == div_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            div_q      <= '0;
            cnt_q      <= '0;
            left_q     <= '0;
            tog_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            ready_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= div_tick ? '0 : cnt_q + DivWidth'(1);

            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (bus.start) begin
                        div_q   <= bus.clk_div;
                        left_q  <= bus.len;
                        cs_n_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= CS_SETUP;
                    end
                end

                CS_SETUP: begin
                    if (div_tick) begin
                        ready_q <= 1'b1;
                        state_q <= LOAD;
                    end
                end

                LOAD: begin
                    cnt_q <= '0;
                    if (ready_q && bus.tx_valid) begin
                        // bit 7 goes straight to MOSI; the shifter keeps only what is still to send
                        mosi_q  <= bus.tx_data[7];
                        tx_sh_q <= bus.tx_data[6:0];
                        tog_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (div_tick) begin
                        sck_q <= ~sck_q;
                        tog_q <= tog_q + 4'd1;
                        if (!tog_q[0]) begin
                            rx_sh_q <= {rx_sh_q[6:0], tspi_miso_i};
                        end else if (tog_q != 4'd15) begin
                            mosi_q  <= tx_sh_q[6];
                            tx_sh_q <= {tx_sh_q[5:0], 1'b0};
                        end else begin
                            // last falling toggle: byte complete, MOSI keeps bit 0
                            rx_data_q  <= rx_sh_q;
                            rx_valid_q <= 1'b1;
                            if (left_q == '0) begin
                                state_q <= CS_HOLD;
                            end else begin
                                left_q  <= left_q - LenWidth'(1);
                                ready_q <= 1'b1;
                                state_q <= LOAD;
                            end
                        end
                    end
                end

                CS_HOLD: begin
                    if (div_tick) begin
                        cs_n_q  <= 1'b1;
                        mosi_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= CS_GAP;
                    end
                end

                CS_GAP: begin
                    if (div_tick) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.tx_ready = ready_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

    assign tspi_clk_o   = sck_q;
    assign tspi_mosi_o  = mosi_q;
    assign tspi_cs_no   = cs_n_q;
endmodule
